// File: rtl/serial_subtractor_pkg.sv
// Shared FSM state codes for the bit-serial arithmetic units.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bi, Bo = borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  logic x;
  logic na;
  logic nx;
  logic t0;
  logic t1;

  assign x  = A ^ B;
  assign D  = x ^ Bi;
  assign na = ~A;
  assign nx = ~x;
  assign t0 = na & B;
  assign t1 = nx & Bi;
  assign Bo = t0 | t1;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sd;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic             d;
  logic             bnx;
  logic             last;

  full_subtractor u_fs (
    .A  (sa[0]),
    .B  (sb[0]),
    .Bi (br),
    .D  (d),
    .Bo (bnx)
  );

  // sd holds the WIDTH-1 bits already produced; res is the full result
  assign res   = {d, sd};
  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_RUN;
      ST_RUN:  if (last)  nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (ready && start) begin
      sa    <= a;
      sb    <= b;
      br    <= bin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (busy) begin
      br  <= bnx;
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sd  <= res[WIDTH-1:1];
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        diff <= res;
        bout <= bnx;
        ovf  <= (a_msb != b_msb) & (d != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready2, busy2, done2, bout2, ovf2;
  logic [1:0] diff2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .ready(ready2), .busy(busy2), .done(done2),
    .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] ia, ib, input logic ibin,
                     output logic [7:0] od, output logic obo, oov);
    int n;
    n = 0;
    while (!ready8 && n < 50) begin tick(); n++; end
    chk("ready8_wait", int'(ready8), 1);
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~ia; b8 = ~ib; bin8 = ~ibin;
    chk("busy8", int'(busy8), 1);
    n = 0;
    while (!done8 && n < 20) begin tick(); n++; end
    chk("latency8", n, 8);
    chk("ready8_in_done", int'(ready8), 0);
    od = diff8; obo = bout8; oov = ovf8;
    tick();
    chk("done8_pulse", int'(done8), 0);
    chk("ready8_back", int'(ready8), 1);
  endtask

  task automatic op2(input logic [1:0] ia, ib, input logic ibin,
                     output logic [1:0] od, output logic obo, oov);
    int n;
    n = 0;
    while (!ready2 && n < 20) begin tick(); n++; end
    a2 = ia; b2 = ib; bin2 = ibin; start2 = 1'b1;
    tick();
    start2 = 1'b0; a2 = ~ia; b2 = ~ib; bin2 = ~ibin;
    n = 0;
    while (!done2 && n < 10) begin tick(); n++; end
    chk("latency2", n, 2);
    od = diff2; obo = bout2; oov = ovf2;
    tick();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, int'(ready8), 1);
    chk({nm, "_busy"},  int'(busy8), 0);
    chk({nm, "_done"},  int'(done8), 0);
    chk({nm, "_diff"},  int'(diff8), 0);
    chk({nm, "_bout"},  int'(bout8), 0);
    chk({nm, "_ovf"},   int'(ovf8), 0);
  endtask

  initial begin
    vec_t       vt[8];
    logic [7:0] d8;
    logic [1:0] d2;
    logic       bo, ov;
    logic [8:0] m9;
    logic [2:0] m3;
    logic [7:0] ra, rb;
    logic [1:0] qa, qb;
    logic       rbin;
    int         n, seen;

    vt[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vt[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vt[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[6] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
    vt[7] = '{8'h42, 8'h42, 1'b1, 8'hFF, 1'b1, 1'b0};

    #2 rst = 1'b1;
    #1 chk_reset("por");
    tick(); tick();
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      op8(vt[i].a, vt[i].b, vt[i].bin, d8, bo, ov);
      chk($sformatf("vec%0d_diff", i), int'(d8), int'(vt[i].diff));
      chk($sformatf("vec%0d_bout", i), int'(bo), int'(vt[i].bout));
      chk($sformatf("vec%0d_ovf", i),  int'(ov), int'(vt[i].ovf));
    end

    // start held high; operands change during RUN
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
    tick();
    chk("hold_busy", int'(busy8), 1);
    tick(); tick(); tick();
    a8 = 8'h10; b8 = 8'h20;
    n = 3;
    while (!done8 && n < 20) begin tick(); n++; end
    chk("hold_lat1", n, 8);
    chk("hold_diff1", int'(diff8), 8'h37);
    chk("hold_bout1", int'(bout8), 0);
    tick();
    chk("hold_done_off", int'(done8), 0);
    chk("hold_ignored", int'(busy8), 0);
    chk("hold_ready", int'(ready8), 1);
    tick();
    start8 = 1'b0;
    chk("hold_accept2", int'(busy8), 1);
    n = 0;
    while (!done8 && n < 20) begin tick(); n++; end
    chk("hold_lat2", n, 8);
    chk("hold_diff2", int'(diff8), 8'hF0);
    chk("hold_bout2", int'(bout8), 1);
    tick();

    // async reset between ops, then mid-operation
    #3 rst = 1'b1;
    #1 chk_reset("rst_idle");
    tick();
    rst = 1'b0;
    tick();
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst = 1'b1;
    #1 chk_reset("rst_run");
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || diff8 != 8'h00) seen++;
    end
    chk("rst_no_result", seen, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      op8(ra, rb, rbin, d8, bo, ov);
      m9 = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
      chk("rnd8_diff", int'(d8), int'(m9[7:0]));
      chk("rnd8_bout", int'(bo), int'(m9[8]));
      chk("rnd8_ovf", int'(ov),
          int'((ra[7] != rb[7]) && (m9[7] != ra[7])));
    end

    for (int i = 0; i < 500; i++) begin
      qa = 2'($urandom); qb = 2'($urandom); rbin = 1'($urandom);
      op2(qa, qb, rbin, d2, bo, ov);
      m3 = {1'b0, qa} - {1'b0, qb} - 3'(rbin);
      chk("rnd2_diff", int'(d2), int'(m3[1:0]));
      chk("rnd2_bout", int'(bo), int'(m3[2]));
      chk("rnd2_ovf", int'(ov),
          int'((qa[1] != qb[1]) && (m3[1] != qa[1])));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
